// File: rtl/hazard_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
// Optional performance counters are enabled by defining HAZ_PERF_CNT_EN.
package hazard_pkg;

  localparam int unsigned REG_AW = 4;
  localparam int unsigned PC_REG = 15;
  localparam int unsigned CNT_W  = 16;

  localparam logic [REG_AW-1:0] PC_IDX = REG_AW'(PC_REG);

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE    = 1'b0,
    BR_WAIT = 1'b1
  } haz_state_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] wa3;
    logic              regwrite;
    logic              memtoreg;
    logic              pcwrite;
    logic [REG_AW-1:0] ra1;
    logic [REG_AW-1:0] ra2;
  } stage_info_t;

  // M beats W; the PC is always read from its own path, never forwarded.
  function automatic fwd_sel_t fwd_sel(input logic              m_wr,
                                       input logic [REG_AW-1:0] m_wa3,
                                       input logic              w_wr,
                                       input logic [REG_AW-1:0] w_wa3,
                                       input logic [REG_AW-1:0] ra);
    fwd_sel = FWD_RF;
    if (ra != PC_IDX) begin
      if (m_wr && (m_wa3 == ra)) begin
        fwd_sel = FWD_M;
      end else if (w_wr && (w_wa3 == ra)) begin
        fwd_sel = FWD_W;
      end
    end
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline stage: holds destination/source info of the instruction
// occupying that stage; a bubble or reset loads an invalid entry.
module hazard_stage_reg
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        bubble_i,
  input  stage_info_t d_i,
  output stage_info_t q_o
);

  stage_info_t info_q;

  always_ff @(posedge clk) begin
    if (reset || bubble_i) begin
      info_q <= '0;
    end else begin
      info_q <= d_i;
    end
  end

  assign q_o = info_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: E-stage forwarding, load-use bubbles and branch-shadow fetch freeze.
// Define HAZ_PERF_CNT_EN to add StallCnt/FlushCnt saturating performance counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] RA1D,
  input  logic [REG_AW-1:0] RA2D,
  input  logic [REG_AW-1:0] WA3D,
  input  logic              RegWriteD,
  input  logic              MemtoRegD,
  input  logic              PCWriteD,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              EnF,
  output logic              EnD,
  output logic              FlushD,
  output logic              FlushE
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
`endif
);

  haz_state_t  state_q, state_d;
  stage_info_t d_info, e_q, m_q, w_q;
  logic        ld_haz;
  logic        e_bubble;

  assign d_info = '{valid: 1'b1, wa3: WA3D, regwrite: RegWriteD, memtoreg: MemtoRegD,
                    pcwrite: PCWriteD, ra1: RA1D, ra2: RA2D};

  // A squashed (FlushD) D instruction is wrong-path and must not enter E as valid.
  assign e_bubble = !EnD || FlushE || FlushD;

  hazard_stage_reg u_stage_e (.clk(clk), .reset(reset), .bubble_i(e_bubble), .d_i(d_info), .q_o(e_q));
  hazard_stage_reg u_stage_m (.clk(clk), .reset(reset), .bubble_i(1'b0),     .d_i(e_q),    .q_o(m_q));
  hazard_stage_reg u_stage_w (.clk(clk), .reset(reset), .bubble_i(1'b0),     .d_i(m_q),    .q_o(w_q));

  logic unused_w;
  assign unused_w = ^{w_q.memtoreg, w_q.ra1, w_q.ra2};

  assign ForwardAE = fwd_sel(m_q.valid && m_q.regwrite, m_q.wa3,
                             w_q.valid && w_q.regwrite, w_q.wa3, e_q.ra1);
  assign ForwardBE = fwd_sel(m_q.valid && m_q.regwrite, m_q.wa3,
                             w_q.valid && w_q.regwrite, w_q.wa3, e_q.ra2);

  assign ld_haz = (state_q == IDLE) && e_q.valid && e_q.memtoreg && e_q.regwrite &&
                  ((e_q.wa3 == RA1D) || (e_q.wa3 == RA2D)) && (e_q.wa3 != PC_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Load-use bubble takes priority; a branch held in D enters BR_WAIT a cycle later.
  always_comb begin
    state_d = state_q;
    EnF     = 1'b1;
    EnD     = 1'b1;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_haz) begin
          EnF    = 1'b0;
          EnD    = 1'b0;
          FlushE = 1'b1;
        end else if (PCWriteD) begin
          state_d = BR_WAIT;
        end
      end
      BR_WAIT: begin
        EnF    = 1'b0;
        FlushD = 1'b1;
        if (w_q.valid && w_q.pcwrite) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (ld_haz && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if ((state_q == BR_WAIT) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed instruction streams with
// hand-computed per-cycle forwarding/stall/flush expectations.
module tb_pipeline_hazard_ctrl;
  import hazard_pkg::*;

  typedef struct packed {
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa3;
    logic       rw;
    logic       mtr;
    logic       pcw;
  } ins_t;

  typedef struct {
    int         id;
    logic [7:0] v;
  } exp_t;

  localparam logic [1:0] F0 = 2'b00;
  localparam logic [1:0] FW = 2'b01;
  localparam logic [1:0] FM = 2'b10;
  // {EnF, EnD, FlushD, FlushE}
  localparam logic [3:0] C_RUN   = 4'b1100;
  localparam logic [3:0] C_STALL = 4'b0001;
  localparam logic [3:0] C_BR    = 4'b0110;
  localparam ins_t       NOP     = '0;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       RA1D, RA2D, WA3D;
  logic             RegWriteD, MemtoRegD, PCWriteD;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             EnF, EnD, FlushD, FlushE;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] StallCnt, FlushCnt;
`endif

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCWriteD(PCWriteD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .EnF(EnF), .EnD(EnD), .FlushD(FlushD), .FlushE(FlushE)
`ifdef HAZ_PERF_CNT_EN
    , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
  );

  function automatic ins_t alu(input int rd, input int rn, input int rm);
    alu = '{ra1: 4'(rn), ra2: 4'(rm), wa3: 4'(rd), rw: 1'b1, mtr: 1'b0, pcw: 1'b0};
  endfunction

  function automatic ins_t ldr(input int rd, input int rn);
    ldr = '{ra1: 4'(rn), ra2: 4'd0, wa3: 4'(rd), rw: 1'b1, mtr: 1'b1, pcw: 1'b0};
  endfunction

  function automatic ins_t br(input int rn);
    br = '{ra1: 4'(rn), ra2: 4'd0, wa3: 4'd0, rw: 1'b0, mtr: 1'b0, pcw: 1'b1};
  endfunction

  task automatic drive(input ins_t i);
    RA1D = i.ra1; RA2D = i.ra2; WA3D = i.wa3;
    RegWriteD = i.rw; MemtoRegD = i.mtr; PCWriteD = i.pcw;
  endtask

  task automatic push(input logic [1:0] fa, input logic [1:0] fb, input logic [3:0] ctl);
    exp_t e;
    e.id = cyc;
    e.v  = {fa, fb, ctl};
    exp_q.push_back(e);
  endtask

  // One cycle: present the D instruction and queue what the controller must show.
  task automatic step(input ins_t i, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [3:0] ctl);
    @(posedge clk);
    #1;
    cyc++;
    reset = 1'b0;
    drive(i);
    push(fa, fb, ctl);
  endtask

  task automatic step_rst();
    @(posedge clk);
    #1;
    cyc++;
    reset = 1'b1;
    drive(NOP);
  endtask

  task automatic cnt(input int st, input int fl);
`ifdef HAZ_PERF_CNT_EN
    @(negedge clk);
    #1;
    checks++;
    if (StallCnt !== CNT_W'(st) || FlushCnt !== CNT_W'(fl)) begin
      errors++;
      $display("FAIL counters cyc %0d: got StallCnt=%0d FlushCnt=%0d, expected %0d/%0d",
               cyc, StallCnt, FlushCnt, st, fl);
    end
`else
    if (st < 0 || fl < 0) $display("negative counter expectation ignored");
`endif
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t       e;
      logic [7:0] got;
      e   = exp_q.pop_front();
      got = {ForwardAE, ForwardBE, EnF, EnD, FlushD, FlushE};
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL ctl cyc %0d: got fa=%b fb=%b enf=%b end=%b fd=%b fe=%b, expected fa=%b fb=%b enf=%b end=%b fd=%b fe=%b",
                 e.id, got[7:6], got[5:4], got[3], got[2], got[1], got[0],
                 e.v[7:6], e.v[5:4], e.v[3], e.v[2], e.v[1], e.v[0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive(NOP);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    push(F0, F0, C_RUN);

    // ALU result forwarded from M, then from W with a NOP in between; M beats W
    step(alu(1, 2, 3), F0, F0, C_RUN);
    step(alu(4, 1, 5), F0, F0, C_RUN);
    step(NOP,          FM, F0, C_RUN);
    step(NOP,          F0, F0, C_RUN);
    step(alu(1, 2, 3), F0, F0, C_RUN);
    step(NOP,          F0, F0, C_RUN);
    step(alu(4, 1, 5), F0, F0, C_RUN);
    step(NOP,          FW, F0, C_RUN);
    step(NOP,          F0, F0, C_RUN);
    step(alu(1, 2, 3), F0, F0, C_RUN);
    step(alu(1, 6, 7), F0, F0, C_RUN);
    step(alu(4, 5, 1), F0, F0, C_RUN);
    step(NOP,          F0, FM, C_RUN);
    step(NOP,          F0, F0, C_RUN);
    step(NOP,          F0, F0, C_RUN);

    // Load-use: one bubble, then both operands from W
    step(ldr(1, 0),    F0, F0, C_RUN);
    step(alu(2, 1, 1), F0, F0, C_STALL);
    step(alu(2, 1, 1), F0, F0, C_RUN);
    step(NOP,          FW, FW, C_RUN);
    step(NOP,          F0, F0, C_RUN);
    cnt(1, 0);

    // Branch: three shadow cycles; wrong-path writes to R5/R6/R7 must never forward
    step(br(0),        F0, F0, C_RUN);
    step(alu(7, 8, 9), F0, F0, C_BR);
    step(alu(6, 7, 7), F0, F0, C_BR);
    step(alu(5, 7, 6), F0, F0, C_BR);
    step(alu(3, 7, 6), F0, F0, C_RUN);
    step(NOP,          F0, F0, C_RUN);
    step(NOP,          F0, F0, C_RUN);
    cnt(1, 3);

    // Load feeding a branch: stall first, then branch shadow
    step(ldr(1, 0),    F0, F0, C_RUN);
    step(br(1),        F0, F0, C_STALL);
    step(br(1),        F0, F0, C_RUN);
    step(NOP,          FW, F0, C_BR);
    step(NOP,          F0, F0, C_BR);
    step(NOP,          F0, F0, C_BR);
    step(NOP,          F0, F0, C_RUN);
    cnt(2, 6);

    // Writes to R15: treated as a branch, never forwarded, never a load-use source
    step('{ra1: 4'd1, ra2: 4'd2, wa3: 4'd15, rw: 1'b1, mtr: 1'b0, pcw: 1'b1}, F0, F0, C_RUN);
    step(alu(3, 15, 15), F0, F0, C_BR);
    step(alu(3, 15, 15), F0, F0, C_BR);
    step(alu(3, 15, 15), F0, F0, C_BR);
    step(alu(3, 15, 15), F0, F0, C_RUN);
    step(ldr(15, 0),     F0, F0, C_RUN);
    step(alu(4, 15, 15), F0, F0, C_RUN);
    step(alu(5, 15, 15), F0, F0, C_RUN);
    step(NOP,            F0, F0, C_RUN);
    step(NOP,            F0, F0, C_RUN);
    step(NOP,            F0, F0, C_RUN);
    cnt(2, 9);

    // Load-use through the second source only
    step(ldr(2, 0),    F0, F0, C_RUN);
    step(alu(6, 5, 2), F0, F0, C_STALL);
    step(alu(6, 5, 2), F0, F0, C_RUN);
    step(NOP,          F0, FW, C_RUN);
    step(NOP,          F0, F0, C_RUN);
    cnt(3, 9);

    // Reset in the second branch-shadow cycle returns to IDLE immediately
    step(br(0),        F0, F0, C_RUN);
    step(NOP,          F0, F0, C_BR);
    step_rst();
    step(NOP,          F0, F0, C_RUN);
    cnt(0, 0);
    step(NOP,          F0, F0, C_RUN);
    step(NOP,          F0, F0, C_RUN);

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
